// File: rtl/rtc_hms_core.sv
// Binary-clock successor: 24h h/m/s timekeeping on a single clock with a tick enable,
// debounced set buttons, RUN/SET FSM, 12/24h BCD display and a wrapping day counter.

module rtc_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [STAGES-1:0][W-1:0] sync_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];
endmodule

module rtc_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic lvl_i,
  output logic rise_o
);
  localparam int CW = $clog2(CYCLES + 1);

  logic          db_q, db_d, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the input agrees with the accepted level restarts the run.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (lvl_i != db_q) begin
      if (cnt_q == CW'(CYCLES - 1)) db_d = lvl_i;
      else                          cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      db_q   <= 1'b0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      db_q   <= db_d;
      prev_q <= db_q;
      cnt_q  <= cnt_d;
    end
  end

  assign rise_o = db_q & ~prev_q;
endmodule

module rtc_hms_core #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DAY_W           = 8
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             set_en,
  input  logic             mode_24h,
  input  logic             btn_hr,
  input  logic             btn_min,
  output logic             tick,
  output logic             in_set,
  output logic             pm,
  output logic             end_of_day,
  output logic [DAY_W-1:0] day_count,
  output logic [3:0]       sec_1s,
  output logic [3:0]       sec_10s,
  output logic [3:0]       min_1s,
  output logic [3:0]       min_10s,
  output logic [3:0]       hr_1s,
  output logic [3:0]       hr_10s
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);

  typedef enum logic {ST_RUN, ST_SET} state_t;

  state_t           state_q;
  logic [DW-1:0]    div_q;
  logic [4:0]       h_q;
  logic [5:0]       m_q, s_q;
  logic [DAY_W-1:0] day_q;
  logic             eod_q;

  logic       set_s, mode_s;
  logic [1:0] btn_s, inc;
  logic [4:0] hr_disp;

  rtc_sync #(.W(4), .STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clk_100MHz),
    .reset_i (reset),
    .d_i     ({btn_min, btn_hr, mode_24h, set_en}),
    .q_o     ({btn_s[1], btn_s[0], mode_s, set_s})
  );

  // inc[0] = hour, inc[1] = minute
  for (genvar g = 0; g < 2; g++) begin : g_btn
    rtc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i   (clk_100MHz),
      .reset_i (reset),
      .lvl_i   (btn_s[g]),
      .rise_o  (inc[g])
    );
  end

  assign tick = (div_q == DW'(DIV - 1));

  // Mode changes take priority over a coincident tick and restart the divider.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      div_q   <= '0;
      h_q     <= '0;
      m_q     <= '0;
      s_q     <= '0;
      day_q   <= '0;
      eod_q   <= 1'b0;
    end else begin
      eod_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (set_s) begin
            state_q <= ST_SET;
            div_q   <= '0;
            s_q     <= '0;
          end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
              if (s_q == 6'd59) begin
                s_q <= '0;
                if (m_q == 6'd59) begin
                  m_q <= '0;
                  if (h_q == 5'd23) begin
                    h_q   <= '0;
                    day_q <= day_q + 1'b1;
                    eod_q <= 1'b1;
                  end else begin
                    h_q <= h_q + 5'd1;
                  end
                end else begin
                  m_q <= m_q + 6'd1;
                end
              end else begin
                s_q <= s_q + 6'd1;
              end
            end
          end
        end
        ST_SET: begin
          if (!set_s) begin
            state_q <= ST_RUN;
            div_q   <= '0;
          end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
          end
          if (inc[0]) h_q <= (h_q == 5'd23) ? '0 : h_q + 5'd1;
          if (inc[1]) m_q <= (m_q == 6'd59) ? '0 : m_q + 6'd1;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign in_set     = (state_q == ST_SET);
  assign pm         = (h_q >= 5'd12);
  assign end_of_day = eod_q;
  assign day_count  = day_q;

  always_comb begin
    hr_disp = h_q;
    if (!mode_s) begin
      if (h_q == 5'd0)       hr_disp = 5'd12;
      else if (h_q > 5'd12)  hr_disp = h_q - 5'd12;
    end
  end

  function automatic logic [7:0] bcd2(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  assign {hr_10s,  hr_1s}  = bcd2({1'b0, hr_disp});
  assign {min_10s, min_1s} = bcd2(m_q);
  assign {sec_10s, sec_1s} = bcd2(s_q);
endmodule
